// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel valid/ready multiplexer with round-robin or fixed
// channel selection, feeding a single registered output stage.
// One cycle of latency. Drain and refill can happen on the same edge, so
// the mux sustains one word per cycle.
module rr_mux_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel_fixed,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_chan,
    output logic                        out_valid,
    input  logic                        out_ready
);

    // Output stage registers
    logic [WIDTH-1:0]    data_p1;
    logic [SEL_W-1:0]    chan_p1;
    logic                vld_p1;

    // Channel granted most recently in round-robin mode
    logic [SEL_W-1:0]    last_grant;

    // Selection stage (combinational)
    logic [CHANNELS-1:0] grant_p0;
    logic [SEL_W-1:0]    grant_idx_p0;
    logic [WIDTH-1:0]    data_p0;
    logic                can_accept_p0;
    logic                xfer_p0;

    // Convert a one-hot (or zero) grant vector into a channel index
    function automatic logic [SEL_W-1:0] onehot_idx(input logic [CHANNELS-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (oh[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    // Output register has room when empty or being drained this cycle
    assign can_accept_p0 = !vld_p1 || out_ready;

    // Grant: fixed select, or first valid channel after last_grant (wrapping)
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        grant_p0 = '0;
        found    = 1'b0;
        idx      = '0;
        if (mode) begin
            // Out-of-range selects match no loop index, so nothing is granted
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_fixed == SEL_W'(i) && in_valid[i]) grant_p0[i] = 1'b1;
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                idx = SEL_W'((int'(last_grant) + k) % CHANNELS);
                if (!found && in_valid[idx]) begin
                    grant_p0[idx] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    // Data mux driven by the one-hot grant
    always_comb begin
        data_p0 = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_p0[i]) data_p0 = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign grant_idx_p0 = onehot_idx(grant_p0);
    // Reset gating keeps all producers stalled while the block is held in reset
    assign in_ready     = (rst_n && can_accept_p0) ? grant_p0 : '0;
    assign xfer_p0      = |in_ready;

    // Output stage: load on transfer, clear valid on drain, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1    <= '0;
            chan_p1    <= '0;
            vld_p1     <= 1'b0;
            last_grant <= SEL_W'(CHANNELS - 1);
        end else begin
            if (xfer_p0) begin
                data_p1 <= data_p0;
                chan_p1 <= grant_idx_p0;
                vld_p1  <= 1'b1;
                if (!mode) last_grant <= grant_idx_p0;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_chan  = chan_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: directed tests for rr_mux_reg (WIDTH=8, CHANNELS=4).
module tb_rr_mux_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel_fixed;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    // Channel words: ch0..3 = A0, B1, C2, D3
    logic [7:0] words [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    rr_mux_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel_fixed(sel_fixed),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel_fixed = 2'd0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel_fixed = 2'd0;
        in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        total++; if (out_chan !== 2'd0) begin bad++; $display("FAIL reset_chan got=%0d exp=0", out_chan); end
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL post_reset_ready got=%b exp=0001", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'hA0) begin
            bad++; $display("FAIL post_reset_first got v=%b c=%0d d=%h exp v=1 c=0 d=A0", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_rr_stream();
        apply_reset();
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_chan !== 2'(k % 4) || out_data !== words[k % 4]) begin
                bad++; $display("FAIL rr_stream[%0d] got v=%b c=%0d d=%h exp v=1 c=%0d d=%h",
                                k, out_valid, out_chan, out_data, k % 4, words[k % 4]);
            end
        end
    endtask

    task automatic test_sparse_wrap();
        logic [1:0] exp_seq [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
        apply_reset();
        in_valid = 4'b0100;
        @(posedge clk); #1;
        total++; if (out_chan !== 2'd2 || out_data !== 8'hC2) begin
            bad++; $display("FAIL sparse_setup got c=%0d d=%h exp c=2 d=C2", out_chan, out_data);
        end
        in_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_chan !== exp_seq[k] || out_data !== words[exp_seq[k]]) begin
                bad++; $display("FAIL sparse_wrap[%0d] got v=%b c=%0d d=%h exp c=%0d", k, out_valid, out_chan, out_data, exp_seq[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_valid = 4'b0010;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, in_ready); end
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 8'hB1) begin
                bad++; $display("FAIL bp_hold[%0d] got v=%b c=%0d d=%h exp v=1 c=1 d=B1", k, out_valid, out_chan, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'hC2) begin
            bad++; $display("FAIL bp_refill got v=%b c=%0d d=%h exp v=1 c=2 d=C2", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_fixed();
        apply_reset();
        mode      = 1'b1;
        sel_fixed = 2'd2;
        in_valid  = 4'b1111;
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'hC2) begin
                bad++; $display("FAIL fixed_xfer[%0d] got v=%b c=%0d d=%h exp v=1 c=2 d=C2", k, out_valid, out_chan, out_data);
            end
        end
        // Round-robin pointer must still be at its reset value (next = ch0)
        mode = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL fixed_last_grant got=%b exp=0001", in_ready); end
        mode     = 1'b1;
        in_valid = 4'b1011;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL fixed_invalid_ready got=%b exp=0000", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || out_chan !== 2'd2 || out_data !== 8'hC2) begin
            bad++; $display("FAIL fixed_drain got v=%b c=%0d d=%h exp v=0 c=2 d=C2", out_valid, out_chan, out_data);
        end
        mode = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        in_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || out_chan !== 2'd1) begin
            bad++; $display("FAIL ar_pre got v=%b c=%0d exp v=1 c=1", out_valid, out_chan);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            bad++; $display("FAIL ar_immediate got v=%b c=%0d d=%h exp v=0 c=0 d=00", out_valid, out_chan, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL ar_restart_ready got=%b exp=0001", in_ready); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'hA0) begin
            bad++; $display("FAIL ar_restart got v=%b c=%0d d=%h exp v=1 c=0 d=A0", out_valid, out_chan, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_rr_stream();
        test_sparse_wrap();
        test_backpressure();
        test_fixed();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
